// File: rtl/vx_wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Selection-source encoding and the effective-weight function live here.
package vx_wrr_arbiter_pkg;

  // Widest weight the helper supports; one extra bit of headroom for base+1.
  localparam int MAX_WW = 16;

  typedef logic [MAX_WW:0] wcalc_t;

  typedef enum logic [1:0] {
    SEL_LOCK = 2'd0,
    SEL_CONT = 2'd1,
    SEL_ROT  = 2'd2
  } sel_src_e;

  // A zero weight still earns one grant per turn.
  function automatic wcalc_t weff(input logic [MAX_WW-1:0] w);
    return (w == '0) ? wcalc_t'(1) : {1'b0, w};
  endfunction

endpackage

// File: rtl/vx_wrr_arbiter_rotate_pick.sv
// Combinational rotating priority picker: first set request after last_idx,
// wrapping around, with last_idx itself considered last.
module vx_wrr_arbiter_rotate_pick #(
  parameter int NUM_REQS     = 4,
  parameter int LOG_NUM_REQS = 2
) (
  input  logic [NUM_REQS-1:0]     requests,
  input  logic [LOG_NUM_REQS-1:0] last_idx,
  output logic [NUM_REQS-1:0]     onehot,
  output logic [LOG_NUM_REQS-1:0] index,
  output logic                    valid
);

  logic [NUM_REQS-1:0]   mask;
  logic [2*NUM_REQS-1:0] dbl;

  // Lower half holds only requests above last_idx; upper half is the wrap.
  always_comb begin
    mask   = '0;
    index  = '0;
    valid  = |requests;
    for (int i = 0; i < NUM_REQS; i++) begin
      mask[i] = (i > int'(last_idx));
    end
    dbl = {requests, requests & mask};
    for (int i = 2*NUM_REQS-1; i >= 0; i--) begin
      if (dbl[i]) index = LOG_NUM_REQS'(i % NUM_REQS);
    end
    onehot = valid ? (NUM_REQS'(1) << index) : '0;
  end

endmodule

// File: rtl/vx_wrr_arbiter.sv
// Weighted round-robin arbiter with per-requester quanta and packet locking.
// Holds the credit/lock state machine and the output muxing.
module vx_wrr_arbiter
  import vx_wrr_arbiter_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              requests,
  input  logic [NUM_REQS*WEIGHT_WIDTH-1:0] weights,
  input  logic                             grant_lock,
  output logic [LOG_NUM_REQS-1:0]          grant_index,
  output logic [NUM_REQS-1:0]              grant_onehot,
  output logic                             grant_valid,
  input  logic                             grant_ready
);

  // Handshake: a grant transfers (fires) on a cycle where grant_valid and
  // grant_ready are both high; grant_valid never waits on grant_ready, and
  // without a fire the state holds so the offered grant stays stable.

  typedef struct packed {
    logic [LOG_NUM_REQS-1:0] last_idx;
    logic [WEIGHT_WIDTH-1:0] used_cnt;
    logic                    locked;
  } arb_state_t;

  // state_q is the observable FSM state; sel_src tags where the winner came from.
  arb_state_t state_q, state_n;
  sel_src_e   sel_src;

  logic [WEIGHT_WIDTH-1:0] w_arr [NUM_REQS];
  logic [NUM_REQS-1:0]     rot_onehot;
  logic [LOG_NUM_REQS-1:0] rot_index;
  logic                    rot_valid;
  logic [LOG_NUM_REQS-1:0] win_idx;
  logic                    win_valid;
  logic                    fire;
  wcalc_t                  weff_last, weff_win, inc;
  logic [WEIGHT_WIDTH-1:0] base;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_w
    assign w_arr[g] = weights[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  vx_wrr_arbiter_rotate_pick #(
    .NUM_REQS     (NUM_REQS),
    .LOG_NUM_REQS (LOG_NUM_REQS)
  ) u_rotate_pick (
    .requests (requests),
    .last_idx (state_q.last_idx),
    .onehot   (rot_onehot),
    .index    (rot_index),
    .valid    (rot_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q.last_idx <= LOG_NUM_REQS'(NUM_REQS-1);
      state_q.used_cnt <= '0;
      state_q.locked   <= 1'b0;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    sel_src   = SEL_ROT;
    win_idx   = rot_index;
    win_valid = rot_valid;
    weff_last = weff(MAX_WW'(w_arr[state_q.last_idx]));
    if (state_q.locked) begin
      sel_src   = SEL_LOCK;
      win_idx   = state_q.last_idx;
      win_valid = requests[state_q.last_idx];
    end else if (requests[state_q.last_idx] && (state_q.used_cnt != '0) &&
                 (wcalc_t'(state_q.used_cnt) < weff_last)) begin
      sel_src   = SEL_CONT;
      win_idx   = state_q.last_idx;
      win_valid = 1'b1;
    end

    grant_valid  = win_valid;
    grant_index  = win_valid ? win_idx : '0;
    grant_onehot = win_valid ? (NUM_REQS'(1) << win_idx) : '0;
    fire         = win_valid & grant_ready;

    // Credit carries over only when this grant extends the holder's turn.
    base     = (sel_src == SEL_ROT) ? '0 : state_q.used_cnt;
    weff_win = weff(MAX_WW'(w_arr[win_idx]));
    inc      = wcalc_t'(base) + wcalc_t'(1);

    state_n = state_q;
    if (fire) begin
      state_n.last_idx = win_idx;
      if (grant_lock) begin
        state_n.locked   = 1'b1;
        state_n.used_cnt = base;
      end else begin
        state_n.locked   = 1'b0;
        state_n.used_cnt = (inc >= weff_win) ? '0 : WEIGHT_WIDTH'(inc);
      end
    end
  end

  logic unused_rot_onehot;
  assign unused_rot_onehot = ^rot_onehot;

endmodule

// File: tb/tb_vx_wrr_arbiter.sv
// Directed testbench for vx_wrr_arbiter (NUM_REQS=4, WEIGHT_WIDTH=4).
// Each task drives one scenario and checks grants against hand-computed values.
module tb_vx_wrr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  requests;
  logic [15:0] weights;
  logic        grant_lock;
  logic [1:0]  grant_index;
  logic [3:0]  grant_onehot;
  logic        grant_valid;
  logic        grant_ready;

  int n_checks;
  int n_fail;

  vx_wrr_arbiter #(
    .NUM_REQS     (4),
    .WEIGHT_WIDTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .requests     (requests),
    .weights      (weights),
    .grant_lock   (grant_lock),
    .grant_index  (grant_index),
    .grant_onehot (grant_onehot),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    requests    = 4'b0000;
    grant_lock  = 1'b0;
    grant_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_oh;
    weights = 16'h1111;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b0 || grant_index !== 2'd0 || grant_onehot !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle: got v=%b i=%0d oh=%b expected v=0 i=0 oh=0000",
               grant_valid, grant_index, grant_onehot);
    end
    requests = 4'b1010;
    exp_oh   = 4'b0010;
    #1;
    n_checks++;
    if (grant_valid !== 1'b1 || grant_index !== 2'd1 || grant_onehot !== exp_oh) begin
      n_fail++;
      $display("FAIL reset_first: got v=%b i=%0d oh=%b expected v=1 i=1 oh=%b",
               grant_valid, grant_index, grant_onehot, exp_oh);
    end
    tick();
  endtask

  task automatic test_plain_rr();
    int         exp_seq [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_oh;
    do_reset();
    weights  = 16'h1111;
    requests = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_oh = 4'b0001 << exp_seq[i];
      n_checks++;
      if (grant_valid !== 1'b1 || int'(grant_index) != exp_seq[i] || grant_onehot !== exp_oh) begin
        n_fail++;
        $display("FAIL plain_rr[%0d]: got v=%b i=%0d oh=%b expected v=1 i=%0d oh=%b",
                 i, grant_valid, grant_index, grant_onehot, exp_seq[i], exp_oh);
      end
      tick();
    end
  endtask

  task automatic test_weighted();
    int exp_seq [9] = '{0, 0, 1, 1, 1, 2, 3, 0, 0};
    do_reset();
    weights  = {4'd1, 4'd1, 4'd3, 4'd2};
    requests = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_checks++;
      if (grant_valid !== 1'b1 || int'(grant_index) != exp_seq[i]) begin
        n_fail++;
        $display("FAIL weighted[%0d]: got v=%b i=%0d expected v=1 i=%0d",
                 i, grant_valid, grant_index, exp_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_lock_burst();
    int exp_seq [5] = '{0, 0, 0, 1, 0};
    do_reset();
    weights  = 16'h1111;
    requests = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      grant_lock = (i < 2);
      @(negedge clk);
      n_checks++;
      if (grant_valid !== 1'b1 || int'(grant_index) != exp_seq[i]) begin
        n_fail++;
        $display("FAIL lock_burst[%0d]: got v=%b i=%0d expected v=1 i=%0d",
                 i, grant_valid, grant_index, exp_seq[i]);
      end
      tick();
    end
    grant_lock = 1'b0;
  endtask

  task automatic test_locked_idle();
    do_reset();
    weights    = 16'h1111;
    requests   = 4'b0100;
    grant_lock = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b1 || grant_index !== 2'd2) begin
      n_fail++;
      $display("FAIL lock_take: got v=%b i=%0d expected v=1 i=2", grant_valid, grant_index);
    end
    tick();
    grant_lock = 1'b0;
    requests   = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (grant_valid !== 1'b0 || grant_onehot !== 4'b0000 || grant_index !== 2'd0) begin
        n_fail++;
        $display("FAIL lock_idle[%0d]: got v=%b i=%0d oh=%b expected v=0 i=0 oh=0000",
                 i, grant_valid, grant_index, grant_onehot);
      end
      tick();
    end
    requests = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b1 || grant_index !== 2'd2 || grant_onehot !== 4'b0100) begin
      n_fail++;
      $display("FAIL lock_return: got v=%b i=%0d oh=%b expected v=1 i=2 oh=0100",
               grant_valid, grant_index, grant_onehot);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b1 || grant_index !== 2'd3) begin
      n_fail++;
      $display("FAIL lock_release: got v=%b i=%0d expected v=1 i=3", grant_valid, grant_index);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int exp_seq [2] = '{1, 2};
    do_reset();
    weights     = 16'h1111;
    requests    = 4'b0110;
    grant_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (grant_valid !== 1'b1 || grant_index !== 2'd1 || grant_onehot !== 4'b0010) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got v=%b i=%0d oh=%b expected v=1 i=1 oh=0010",
                 i, grant_valid, grant_index, grant_onehot);
      end
      tick();
    end
    grant_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (grant_valid !== 1'b1 || int'(grant_index) != exp_seq[i]) begin
        n_fail++;
        $display("FAIL backpressure_go[%0d]: got v=%b i=%0d expected v=1 i=%0d",
                 i, grant_valid, grant_index, exp_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_zero_weight_reset();
    int zw_seq [2] = '{0, 1};
    int rs_seq [4] = '{0, 0, 0, 1};
    do_reset();
    weights  = {4'd1, 4'd1, 4'd1, 4'd0};
    requests = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (grant_valid !== 1'b1 || int'(grant_index) != zw_seq[i]) begin
        n_fail++;
        $display("FAIL zero_weight[%0d]: got v=%b i=%0d expected v=1 i=%0d",
                 i, grant_valid, grant_index, zw_seq[i]);
      end
      tick();
    end
    weights  = {4'd1, 4'd1, 4'd1, 4'd3};
    requests = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b1 || grant_index !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_quantum_fire: got v=%b i=%0d expected v=1 i=0", grant_valid, grant_index);
    end
    tick();
    reset    = 1'b1;
    requests = 4'b1111;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (grant_valid !== 1'b1 || int'(grant_index) != rs_seq[i]) begin
        n_fail++;
        $display("FAIL reset_mid_quantum[%0d]: got v=%b i=%0d expected v=1 i=%0d",
                 i, grant_valid, grant_index, rs_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_weight_change();
    do_reset();
    weights  = {4'd1, 4'd1, 4'd3, 4'd1};
    requests = 4'b1010;
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b1 || grant_index !== 2'd1) begin
      n_fail++;
      $display("FAIL weight_change_first: got v=%b i=%0d expected v=1 i=1", grant_valid, grant_index);
    end
    tick();
    weights = 16'h1111;
    @(negedge clk);
    n_checks++;
    if (grant_valid !== 1'b1 || grant_index !== 2'd3) begin
      n_fail++;
      $display("FAIL weight_change_rotate: got v=%b i=%0d expected v=1 i=3", grant_valid, grant_index);
    end
    tick();
    requests = 4'b0100;
    weights  = {4'd1, 4'd4, 4'd1, 4'd1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (grant_valid !== 1'b1 || grant_index !== 2'd2) begin
        n_fail++;
        $display("FAIL single_req[%0d]: got v=%b i=%0d expected v=1 i=2", i, grant_valid, grant_index);
      end
      tick();
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    requests    = 4'b0000;
    weights     = 16'h1111;
    grant_lock  = 1'b0;
    grant_ready = 1'b1;
    tick();
    test_reset();
    test_plain_rr();
    test_weighted();
    test_lock_burst();
    test_locked_idle();
    test_backpressure();
    test_zero_weight_reset();
    test_weight_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_wrr_arbiter.md
Name: VX_wrr_arbiter

Overview:
- Weighted round-robin arbiter with packet locking; the next generation of the plain round-robin arbiter.
- Each requester gets a runtime-programmable quantum of consecutive grants before priority rotates.
- A lock input pins the grant to the current winner for multi-beat packets.
- Used in front of shared memory/NoC ports where requesters need unequal bandwidth and bursts must not interleave.

Parameters:
- NUM_REQS, 4: number of requesters (>=1).
- WEIGHT_WIDTH, 4: bit width of each per-requester weight.
- LOG_NUM_REQS, LOG2UP(NUM_REQS): index width (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- requests  in  NUM_REQS  request vector
- weights  in  NUM_REQS*WEIGHT_WIDTH  weight of requester i at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- grant_lock  in  1  sampled on fire: 1 means more beats follow, so hold the grant
- grant_index  out  LOG_NUM_REQS  winner index
- grant_onehot  out  NUM_REQS  winner one-hot
- grant_valid  out  1  grant present
- grant_ready  in  1  consumer accepts grant; fire = grant_valid & grant_ready

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- State registers:
  - last_idx (LOG_NUM_REQS): reset value NUM_REQS-1, so index 0 has first priority.
  - used_cnt (WEIGHT_WIDTH): reset value 0.
  - locked (1): reset value 0.
- Effective weight: weff[i] = (weights[i]==0) ? 1 : weights[i].
- Combinational selection, zero latency from requests to grant. Priority order:
  - LOCK: if locked, winner = last_idx and grant_valid = requests[last_idx]. Other requesters are blocked even when the holder is idle.
  - CONTINUE: else if requests[last_idx] && used_cnt!=0 && used_cnt<weff[last_idx], winner = last_idx.
  - ROTATE: else winner = first set bit scanning last_idx+1, last_idx+2, ... modulo NUM_REQS, with last_idx scanned last. grant_valid = |requests.
- Outputs when grant_valid=0: grant_onehot=0 and grant_index=0.
- Reset output values: with requests=0 all outputs are 0. After reset, any requests vector grants its lowest set index.
- Update on fire (registered, effective next cycle):
  - last_idx <= grant_index.
  - base = used_cnt if the selection came from LOCK or CONTINUE, else 0.
  - If grant_lock=1: locked<=1 and used_cnt<=base. Lock beats consume no credit.
  - If grant_lock=0: locked<=0. Compute base+1 in WEIGHT_WIDTH+1 bits. If base+1 >= weff[winner], used_cnt<=0 (quantum exhausted, rotate next); else used_cnt<=base+1.
- No fire, including grant_ready=0: all state holds and outputs stay stable as long as requests and weights are stable.
- Weight changes take effect immediately. If a weight drops to <= used_cnt mid-quantum, CONTINUE fails and priority rotates. Locking is unaffected.
- CONTINUE holder drops its request: ROTATE applies and the unused quantum is forfeited, because the next fire resets base to 0.
- Single active requester: it is regranted every cycle regardless of weight.
- All weights 1 and grant_lock=0: behaviour is cycle-identical to the plain round-robin arbiter.
- NUM_REQS==1: grant_index=0, grant_onehot=requests, grant_valid=requests[0]. Lock and credit state are kept but have no visible effect.
- Reset mid-quantum or mid-lock: all state returns to its reset values on the next edge and the lock is dropped.

Decomposition:
- Shared package VX_arb_pkg:
  - weff() helper function.
  - Selection-source encoding: SEL_LOCK, SEL_CONT, SEL_ROT, used for the base mux and coverage.
- One sub-module, VX_rotate_pick: combinational rotating priority picker.
  - Inputs: requests, last_idx.
  - Outputs: onehot, index, valid.
  - Implementation: double-width masked priority encode.
- Top level holds the credit/lock FSM and the output muxing.

Test Plan (all with NUM_REQS=4, WEIGHT_WIDTH=4, grant_ready=1 unless stated):
- Plain RR: reset, weights all 1, requests=4'b1111, lock=0 -> grant_index 0,1,2,3,0 on consecutive cycles.
- Weighted quanta: weights w0=2, w1=3, w2=1, w3=1, requests=1111 -> sequence 0,0,1,1,1,2,3,0,0.
- Lock burst: weights all 1, requests=0011, grant_lock=1 on the first two fires then 0 -> grants 0,0,0,1,0.
- Locked holder idles: fire index 2 with lock=1, then requests=1011 -> grant_valid=0 and onehot=0 until requests[2]=1 returns -> grant 2.
- Backpressure: requests=0110, grant_ready=0 for 3 cycles -> grant_index holds at 1 and state is unchanged; then ready=1 -> grants 1,2.
- Zero weight and reset mid-quantum: w0=0 gives a single grant before rotation. Then set w0=3, fire index 0 once, assert reset one cycle, requests=1111 -> grants 0,0,0,1.
